// File: rtl/gx_pkg.sv
// Shared definitions for the gate-array pixel path: mode codes, pen decode,
// default geometry and the palette entry type.
package gx_pkg;

    localparam int GX_CH_W     = 4;
    localparam int GX_NPENS    = 16;
    localparam int GX_SCROLL_W = 4;

    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

    // Palette index of the border colour (one past the last ink)
    localparam logic [4:0] BORDER_IDX = 5'(GX_NPENS);

    typedef logic [3*GX_CH_W-1:0] rgb_t;

    // Pen of the leftmost pixel held in s; later pixels reach it by left shifts.
    function automatic logic [3:0] pen_decode(input logic [1:0] m,
                                              input logic [7:0] s,
                                              input logic [3:0] mask);
        logic [3:0] p;
        case (m)
            MODE0:        p = {s[1], s[5], s[3], s[7]};
            MODE2:        p = {3'b000, s[7]};
            MODE1, MODE3: p = {2'b00, s[3], s[7]};
            default:      p = 4'd0;
        endcase
        return p & mask;
    endfunction

endpackage

// File: rtl/gx_scroll_delay.sv
// Tap-select shift line for the {border,pen} stream; tap 0 bypasses the line,
// tap k returns the value that entered k pixel ticks earlier.
module gx_scroll_delay
    import gx_pkg::*;
#(
    parameter int         W       = 5,
    parameter int         TAP_W   = GX_SCROLL_W,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [W-1:0]     din,
    input  logic [TAP_W-1:0] tap,
    output logic [W-1:0]     dout
);

    localparam int DEPTH = (1 << TAP_W) - 1;

    logic [W-1:0] taps [DEPTH+1];

    assign taps[0] = din;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] q_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= RST_VAL;
                end else if (cen) begin
                    q_reg <= taps[gi];
                end
            end
            assign taps[gi+1] = q_reg;
        end
    endgenerate

    assign dout = taps[tap];

endmodule

// File: rtl/gx_pixel_pipeline.sv
// Video byte serialiser with soft horizontal scroll and writable RGB palette,
// feeding a two-stage registered colour output.
module gx_pixel_pipeline
    import gx_pkg::*;
#(
    parameter int CH_W     = GX_CH_W,
    parameter int NPENS    = GX_NPENS,
    parameter int SCROLL_W = GX_SCROLL_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen_16,
    input  logic                load,
    input  logic [7:0]          video,
    input  logic                dispen,
    input  logic [1:0]          mode,
    input  logic                mode_sync,
    input  logic [SCROLL_W-1:0] scroll,
    input  logic                force_blank,
    input  logic                pal_we,
    input  logic [4:0]          pal_addr,
    input  logic [3*CH_W-1:0]   pal_wdata,
    output logic [3:0]          pen_id,
    output logic                is_border,
    output logic [3*CH_W-1:0]   rgb
);

    localparam logic [3:0] PEN_MASK    = 4'(NPENS - 1);
    localparam logic [4:0] BORDER_ADDR = 5'(NPENS);
    localparam logic [4:0] BORDER_PAIR = 5'b10000;

    logic [1:0]          mode_q_reg;
    logic [SCROLL_W-1:0] scroll_q_reg;
    logic [1:0]          act_mode_reg;
    logic [7:0]          shreg_reg;
    logic                dispen_q_reg;
    logic [2:0]          tc_reg;
    logic                shift_tick;
    logic [3:0]          pen_raw;
    logic [4:0]          pair_in;
    logic [4:0]          pair_tap;
    logic [4:0]          s1_pair_reg;
    logic [4:0]          s2_pair_reg;
    logic [4:0]          rd_addr;
    logic [3*CH_W-1:0]   pal_rd_reg;
    logic [3*CH_W-1:0]   pal_mem [NPENS+1];

    // Committed settings; mode is latched into act_mode only at the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q_reg   <= MODE1;
            scroll_q_reg <= '0;
        end else if (mode_sync) begin
            mode_q_reg   <= mode;
            scroll_q_reg <= scroll;
        end
    end

    always_comb begin
        shift_tick = 1'b0;
        case (act_mode_reg)
            MODE2:   shift_tick = 1'b1;
            MODE1:   shift_tick = tc_reg[0];
            default: shift_tick = (tc_reg == 3'd3);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_reg    <= '0;
            dispen_q_reg <= 1'b0;
            tc_reg       <= '0;
            act_mode_reg <= MODE1;
        end else if (cen_16) begin
            if (load) begin
                shreg_reg    <= video;
                dispen_q_reg <= dispen;
                tc_reg       <= '0;
                act_mode_reg <= mode_q_reg;
            end else begin
                tc_reg <= tc_reg + 3'd1;
                if (shift_tick) begin
                    shreg_reg <= {shreg_reg[6:0], 1'b0};
                end
            end
        end
    end

    assign pen_raw = pen_decode(act_mode_reg, shreg_reg, PEN_MASK);
    assign pair_in = dispen_q_reg ? {1'b0, pen_raw} : BORDER_PAIR;

    gx_scroll_delay #(
        .W       (5),
        .TAP_W   (SCROLL_W),
        .RST_VAL (BORDER_PAIR)
    ) u_scroll_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen_16),
        .din   (pair_in),
        .tap   (scroll_q_reg),
        .dout  (pair_tap)
    );

    assign rd_addr = s1_pair_reg[4] ? BORDER_ADDR : {1'b0, s1_pair_reg[3:0]};

    always_ff @(posedge clk) begin
        if (pal_we && (pal_addr <= BORDER_ADDR)) begin
            pal_mem[pal_addr] <= pal_wdata;
        end
    end

    // Registered palette read; a same-clock write to the read entry wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_pair_reg <= BORDER_PAIR;
            s2_pair_reg <= BORDER_PAIR;
            pal_rd_reg  <= '0;
        end else if (cen_16) begin
            s1_pair_reg <= pair_tap;
            s2_pair_reg <= s1_pair_reg;
            pal_rd_reg  <= (pal_we && (pal_addr == rd_addr)) ? pal_wdata : pal_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= '0;
            pen_id    <= '0;
            is_border <= 1'b1;
        end else if (cen_16) begin
            rgb       <= force_blank ? '0 : pal_rd_reg;
            pen_id    <= s2_pair_reg[4] ? 4'd0 : s2_pair_reg[3:0];
            is_border <= s2_pair_reg[4];
        end
    end

endmodule

// File: tb/tb_gx_pixel_pipeline.sv
// Randomised bench for gx_pixel_pipeline against a pixel-stream reference model.
module tb_gx_pixel_pipeline;
    import gx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cen_16 = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  video = 8'd0;
    logic        dispen = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        mode_sync = 1'b0;
    logic [3:0]  scroll = 4'd0;
    logic        force_blank = 1'b0;
    logic        pal_we = 1'b0;
    logic [4:0]  pal_addr = 5'd0;
    rgb_t        pal_wdata = '0;
    logic [3:0]  pen_id;
    logic        is_border;
    rgb_t        rgb;

    always #5 clk = ~clk;

    gx_pixel_pipeline dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen_16      (cen_16),
        .load        (load),
        .video       (video),
        .dispen      (dispen),
        .mode        (mode),
        .mode_sync   (mode_sync),
        .scroll      (scroll),
        .force_blank (force_blank),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_wdata   (pal_wdata),
        .pen_id      (pen_id),
        .is_border   (is_border),
        .rgb         (rgb)
    );

    int checks = 0;
    int failures = 0;
    logic gaps_on = 1'b0;
    logic fb_on = 1'b0;

    // Reference model: the pixel each tick, by tick number, plus the palette
    rgb_t       pal_m [17];
    rgb_t       pal_t [17];
    logic [4:0] src_hist [4096];
    int         k_hist [4096];
    int         e;
    logic [7:0] cur_v;
    logic       cur_d;
    logic [1:0] cur_m;
    int         t_m;
    logic [1:0] modeq_m;
    int         scroll_m;
    rgb_t       exp_rgb;
    logic [3:0] exp_pen;
    logic       exp_border;

    function automatic logic bit_at(input logic [7:0] b, input int i);
        return (i >= 0 && i < 8) ? b[i] : 1'b0;
    endfunction

    // Pixel p of a byte: mode 2 = 8 px x 1 tick, mode 1 = 4 px x 2, modes 0/3 = 2 px x 4
    function automatic logic [4:0] pixel_of(input logic [7:0] b, input logic d,
                                            input logic [1:0] m, input int t);
        int p;
        logic [3:0] pen;
        if (!d) return 5'b10000;
        case (m)
            2'd2: begin p = t;     pen = {3'b000, bit_at(b, 7-p)}; end
            2'd0: begin p = t / 4; pen = {bit_at(b, 1-p), bit_at(b, 5-p), bit_at(b, 3-p), bit_at(b, 7-p)}; end
            2'd1: begin p = t / 2; pen = {2'b00, bit_at(b, 3-p), bit_at(b, 7-p)}; end
            default: begin p = t / 4; pen = {2'b00, bit_at(b, 3-p), bit_at(b, 7-p)}; end
        endcase
        return {1'b0, pen};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (tick %0d)", tag, obs, expv, e);
        end
    endtask

    task automatic model_reset();
        e = 0; cur_v = 8'd0; cur_d = 1'b0; cur_m = 2'd1; t_m = 0;
        modeq_m = 2'd1; scroll_m = 0;
        exp_rgb = '0; exp_pen = 4'd0; exp_border = 1'b1;
    endtask

    // One clock: update the model from the inputs present at the edge, then compare
    task automatic step();
        int km, m, idx;
        logic [4:0] s;
        @(posedge clk);
        if (cen_16) begin
            e++;
            km = (e - 2 >= 1) ? k_hist[e-2] : 0;
            m  = e - 3 - km;
            s  = (e - 2 >= 1 && m >= 1) ? src_hist[m] : 5'b10000;
            idx = s[4] ? int'(BORDER_IDX) : int'(s[3:0]);
            exp_border = s[4];
            exp_pen    = s[4] ? 4'd0 : s[3:0];
            exp_rgb    = (force_blank || e < 2) ? '0 : pal_t[idx];
            if (load) begin
                cur_v = video; cur_d = dispen; cur_m = modeq_m; t_m = 0;
            end else begin
                t_m++;
            end
            src_hist[e] = pixel_of(cur_v, cur_d, cur_m, t_m);
            k_hist[e]   = scroll_m;
        end
        if (mode_sync) begin modeq_m = mode; scroll_m = int'(scroll); end
        if (pal_we && pal_addr <= BORDER_IDX) pal_m[pal_addr] = pal_wdata;
        if (cen_16) pal_t = pal_m;
        #1;
        check("rgb", rgb, exp_rgb);
        check("pen_id", {8'd0, pen_id}, {8'd0, exp_pen});
        check("is_border", {11'd0, is_border}, {11'd0, exp_border});
        load = 1'b0; mode_sync = 1'b0; pal_we = 1'b0;
    endtask

    task automatic pal_write(input logic [4:0] a, input rgb_t d);
        cen_16 = 1'b0; pal_we = 1'b1; pal_addr = a; pal_wdata = d;
        step();
    endtask

    task automatic commit(input logic [1:0] m, input logic [3:0] s);
        cen_16 = 1'b0; mode_sync = 1'b1; mode = m; scroll = s;
        step();
    endtask

    task automatic send_byte(input logic [7:0] v, input logic d, input int sync_at,
                             input logic [1:0] sm, input logic [3:0] ss, input int wr_at,
                             input logic [4:0] wa, input rgb_t wd);
        int ng;
        for (int i = 0; i < 8; i++) begin
            ng = (gaps_on && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            for (int g = 0; g < ng; g++) begin
                cen_16 = 1'b0; load = 1'($urandom_range(0, 1)); video = 8'($urandom);
                force_blank = 1'($urandom_range(0, 1));
                step();
            end
            cen_16 = 1'b1;
            load   = (i == 0);
            video  = (i == 0) ? v : 8'($urandom);
            dispen = (i == 0) ? d : 1'($urandom_range(0, 1));
            force_blank = fb_on && ($urandom_range(0, 5) == 0);
            if (i == sync_at) begin mode_sync = 1'b1; mode = sm; scroll = ss; end
            if (i == wr_at) begin pal_we = 1'b1; pal_addr = wa; pal_wdata = wd; end
            step();
        end
        cen_16 = 1'b0; force_blank = 1'b0;
    endtask

    task automatic plain_byte(input logic [7:0] v, input logic d);
        send_byte(v, d, -1, 2'd0, 4'd0, -1, 5'd0, '0);
    endtask

    initial begin
        int sa, wi;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_rgb", rgb, 12'h000);
        check("reset_pen", {8'd0, pen_id}, 12'd0);
        check("reset_border", {11'd0, is_border}, 12'd1);

        pal_write(5'd0, 12'h000);
        pal_write(5'd1, 12'hFFF);
        for (int i = 2; i < 16; i++) pal_write(5'(i), 12'($urandom));
        pal_write(5'd16, 12'h0F0);
        @(negedge clk) rst_n = 1'b1;

        // Mode 2, alternating pattern, no scroll
        commit(2'd2, 4'd0);
        plain_byte(8'hA5, 1'b1);
        plain_byte(8'h3C, 1'b1);
        // Mode 0 single-pixel bytes
        commit(2'd0, 4'd0);
        plain_byte(8'h80, 1'b1);
        plain_byte(8'h40, 1'b1);
        // Mode 1 switched to mode 2 mid-byte
        commit(2'd1, 4'd0);
        send_byte(8'hC3, 1'b1, 3, 2'd2, 4'd0, -1, 5'd0, '0);
        plain_byte(8'h96, 1'b1);
        // Border bytes
        plain_byte(8'hFF, 1'b0);
        plain_byte(8'h5A, 1'b0);
        // Scroll delays 5 and 15
        commit(2'd2, 4'd5);
        plain_byte(8'hF0, 1'b1);
        plain_byte(8'h0F, 1'b0);
        plain_byte(8'h81, 1'b1);
        commit(2'd2, 4'd15);
        plain_byte(8'hA5, 1'b1);
        plain_byte(8'h00, 1'b0);
        plain_byte(8'hFF, 1'b1);
        plain_byte(8'h00, 1'b0);
        // Palette write to pen 1 while pen 1 is being read
        commit(2'd2, 4'd0);
        plain_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1, -1, 2'd0, 4'd0, 4, 5'd1, 12'h5A3);
        send_byte(8'hFF, 1'b1, -1, 2'd0, 4'd0, 2, 5'd20, 12'h123);
        // Mode 3
        commit(2'd3, 4'd2);
        plain_byte(8'h88, 1'b1);
        plain_byte(8'h11, 1'b1);

        // Randomised traffic with hold gaps, blanking, commits and palette writes
        gaps_on = 1'b1; fb_on = 1'b1;
        for (int b = 0; b < 60; b++) begin
            sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            wi = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            send_byte(8'($urandom), ($urandom_range(0, 5) != 0), sa, 2'($urandom),
                      4'($urandom), wi, 5'($urandom_range(0, 18)), 12'($urandom));
        end
        gaps_on = 1'b0; fb_on = 1'b0;

        // Asynchronous reset in the middle of a line
        commit(2'd2, 4'd0);
        plain_byte(8'hFF, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", rgb, 12'h000);
        check("async_rst_pen", {8'd0, pen_id}, 12'd0);
        check("async_rst_border", {11'd0, is_border}, 12'd1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        plain_byte(8'hE7, 1'b1);
        plain_byte(8'h18, 1'b1);
        plain_byte(8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
